// File: rtl/ring_nic.sv
// Network interface between a processor node and its ring router port.
// Buffers one outgoing packet for injection and one ejected packet for the processor.
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_ri,
  input  logic                  net_si,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_ro,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [DATA_WIDTH-1:0] in_buf;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  in_full;
  logic                  out_full;

  logic                  proc_rd;
  logic                  proc_wr;
  logic                  eject;
  logic                  in_drain;
  logic                  inject;
  logic                  out_wr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign proc_rd  = nicEn & ~nicWrEn;
  assign proc_wr  = nicEn & nicWrEn;
  assign eject    = net_si & ~in_full;
  assign in_drain = proc_rd & (addr == ADDR_IN_BUF);
  // A packet may only leave in the phase opposite to its virtual channel tag.
  assign inject   = out_full & net_ri & (out_buf[VC_BIT] != net_polarity);
  // Writes into a full output buffer, including on the injecting edge, are dropped.
  assign out_wr   = proc_wr & (addr == ADDR_OUT_BUF) & ~out_full;
  assign net_ro   = ~in_full;

  always_comb begin
    rd_data = '0;
    unique case (addr)
      ADDR_IN_BUF:   rd_data = in_buf;
      ADDR_IN_STAT:  rd_data = {{(DATA_WIDTH-1){1'b0}}, in_full};
      ADDR_OUT_BUF:  rd_data = out_buf;
      ADDR_OUT_STAT: rd_data = {{(DATA_WIDTH-1){1'b0}}, out_full};
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_out <= '0;
    end else if (proc_rd) begin
      d_out <= rd_data;
    end
  end

  // Ejection side; arrival needs an empty buffer, so it never races a drain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (eject) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end else if (in_drain) begin
      in_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
      net_so   <= 1'b0;
      net_do   <= '0;
    end else if (inject) begin
      out_full <= 1'b0;
      net_so   <= 1'b1;
      net_do   <= out_buf;
    end else begin
      net_so <= 1'b0;
      if (out_wr) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Directed self-checking bench for ring_nic.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_ring_nic;

  localparam logic [63:0] PKT_A   = 64'h300f_3412_ffff_ffff;
  localparam logic [63:0] PKT_B   = 64'h0000_0000_0000_0b0b;
  localparam logic [63:0] PKT_D   = 64'h0000_0000_0000_0d0d;
  localparam logic [63:0] PKT_E   = 64'h8000_0000_0000_00e5;
  localparam logic [63:0] PKT_IN1 = 64'hb001_0002_dead_beef;
  localparam logic [63:0] PKT_IN2 = 64'h1234_5678_9abc_def0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ri;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ro;
  logic        net_polarity;

  int   tests = 0;
  int   failures = 0;
  logic sampled_pol;
  int   waited;

  ring_nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_do(net_do),
    .net_ri(net_ri), .net_si(net_si), .net_di(net_di), .net_ro(net_ro),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  // Advance one edge; remember the phase the DUT saw, then flip it for the next edge.
  task automatic tick();
    @(posedge clk);
    sampled_pol = net_polarity;
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic applyStimulus(input logic en, input logic wr, input logic [1:0] a,
                               input logic [63:0] d);
    nicEn   = en;
    nicWrEn = wr;
    addr    = a;
    d_in    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic procRead(input logic [1:0] a);
    applyStimulus(1'b1, 1'b0, a, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0);
  endtask

  task automatic procWrite(input logic [1:0] a, input logic [63:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0);
  endtask

  task automatic waitInject(input int budget);
    waited = 0;
    while (net_so !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("inject_seen", 64'(net_so), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    net_ri = 1'b0;
    net_si = 1'b0;
    net_di = '0;
    net_polarity = 1'b0;
    sampled_pol = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 64'd0);

    // Reset
    tick();
    tick();
    checkOutput("rst_d_out", d_out, 64'd0);
    checkOutput("rst_net_so", 64'(net_so), 64'd0);
    checkOutput("rst_net_ro", 64'(net_ro), 64'd1);
    checkOutput("rst_net_do", net_do, 64'd0);
    reset = 1'b1;
    procRead(2'b01);
    checkOutput("rst_in_stat", d_out, 64'd0);
    procRead(2'b11);
    checkOutput("rst_out_stat", d_out, 64'd0);

    // Even-VC injection needs polarity 1 at the injecting edge
    net_ri = 1'b1;
    procWrite(2'b10, PKT_A);
    waitInject(4);
    checkOutput("inj_a_latency_ok", 64'(waited <= 2), 64'd1);
    checkOutput("inj_a_polarity", 64'(sampled_pol), 64'd1);
    checkOutput("inj_a_net_do", net_do, PKT_A);
    tick();
    checkOutput("inj_a_one_cycle", 64'(net_so), 64'd0);
    checkOutput("inj_a_do_hold", net_do, PKT_A);
    procRead(2'b11);
    checkOutput("inj_a_out_stat", d_out, 64'd0);

    // Stall with router not ready; a second write is dropped
    net_ri = 1'b0;
    procWrite(2'b10, PKT_B);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall_no_so", 64'(net_so), 64'd0);
    end
    procWrite(2'b10, PKT_C_DUMMY());
    procRead(2'b11);
    checkOutput("stall_out_stat", d_out, 64'd1);
    procRead(2'b10);
    checkOutput("stall_out_buf", d_out, PKT_B);

    // Raise ready on a matching phase while writing on the injecting edge
    if (net_polarity !== 1'b1) tick();
    net_ri = 1'b1;
    procWrite(2'b10, PKT_D);
    checkOutput("inj_b_so", 64'(net_so), 64'd1);
    checkOutput("inj_b_net_do", net_do, PKT_B);
    procRead(2'b11);
    checkOutput("same_edge_wr_dropped", d_out, 64'd0);
    procRead(2'b10);
    checkOutput("out_buf_still_b", d_out, PKT_B);

    // Odd-VC injection needs polarity 0
    procWrite(2'b10, PKT_E);
    waitInject(4);
    checkOutput("inj_e_polarity", 64'(sampled_pol), 64'd0);
    checkOutput("inj_e_net_do", net_do, PKT_E);

    // Ejection, protocol-error second arrival, drain
    net_si = 1'b1;
    net_di = PKT_IN1;
    tick();
    net_si = 1'b0;
    net_di = '0;
    checkOutput("ej_net_ro_low", 64'(net_ro), 64'd0);
    procRead(2'b01);
    checkOutput("ej_in_stat", d_out, 64'd1);
    net_si = 1'b1;
    net_di = PKT_IN2;
    tick();
    net_si = 1'b0;
    net_di = '0;
    checkOutput("ej_still_full", 64'(net_ro), 64'd0);
    procRead(2'b00);
    checkOutput("ej_read_first", d_out, PKT_IN1);
    checkOutput("ej_net_ro_high", 64'(net_ro), 64'd1);
    tick();
    checkOutput("d_out_hold", d_out, PKT_IN1);
    procWrite(2'b01, 64'hffff_ffff_ffff_ffff);
    procRead(2'b01);
    checkOutput("ej_in_stat_drained", d_out, 64'd0);
    procRead(2'b00);
    checkOutput("ej_stale_read", d_out, PKT_IN1);
    procRead(2'b01);
    checkOutput("ej_stale_keeps_empty", d_out, 64'd0);
    net_si = 1'b1;
    net_di = PKT_IN2;
    tick();
    net_si = 1'b0;
    procRead(2'b00);
    checkOutput("ej_second_packet", d_out, PKT_IN2);

    // Reset while both buffers are loaded
    net_ri = 1'b0;
    net_si = 1'b1;
    net_di = PKT_IN1;
    procWrite(2'b10, PKT_B);
    net_si = 1'b0;
    procRead(2'b11);
    checkOutput("pre_rst_out_stat", d_out, 64'd1);
    reset = 1'b0;
    tick();
    checkOutput("mid_rst_d_out", d_out, 64'd0);
    checkOutput("mid_rst_net_ro", 64'(net_ro), 64'd1);
    checkOutput("mid_rst_net_do", net_do, 64'd0);
    reset = 1'b1;
    net_ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_no_so", 64'(net_so), 64'd0);
    end
    procRead(2'b11);
    checkOutput("post_rst_out_stat", d_out, 64'd0);
    procRead(2'b00);
    checkOutput("post_rst_in_buf", d_out, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  function automatic logic [63:0] PKT_C_DUMMY();
    return 64'h0000_0000_0000_0c0c;
  endfunction

endmodule
